instruction_loader: RTL

//  Byte-stream program loader; the write-side counterpart of the instruction memory.

---
 rtl/instruction_loader_if.sv | 23 ++
 rtl/instruction_loader.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader_if.sv
// Byte-stream handshake and instruction-memory write port of the program loader.
// master = byte source / memory side, slave = loader.
interface instruction_loader_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
);
  logic                  byteValid;
  logic [7:0]            byteData;
  logic                  byteReady;
  logic                  writeEnable;
  logic [ADDR_WIDTH-1:0] writeAddr;
  logic [DATA_WIDTH-1:0] writeData;

  modport master (
    output byteValid, byteData,
    input  byteReady, writeEnable, writeAddr, writeData
  );

  modport slave (
    input  byteValid, byteData,
    output byteReady, writeEnable, writeAddr, writeData
  );
endinterface

// File: rtl/instruction_loader.sv
// Byte-stream program loader: frame {N_hi, N_lo, 4*N data bytes LSB-first} in, sequential
// instruction-memory writes out. Define CHECKSUM_EN for a trailing XOR checksum byte.
module instruction_loader #(
  parameter int DATA_WIDTH                = 32,
  parameter int INSTRUCTIONMEM_ADDR_WIDTH = 11,
  parameter int RAM_DEPTH                 = 1 << INSTRUCTIONMEM_ADDR_WIDTH
) (
  input  logic                                 clock,
  input  logic                                 resetN,
  instruction_loader_if.slave                  bus,
  input  logic [INSTRUCTIONMEM_ADDR_WIDTH-1:0] baseAddr,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 error
);
  localparam int AW = INSTRUCTIONMEM_ADDR_WIDTH;
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_LO,
    S_DATA,
    S_WRITE
`ifdef CHECKSUM_EN
    , S_CHECK
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            cnt_hi_q, cnt_hi_d;
  logic [AW-1:0]         base_q, base_d;
  logic [CW-1:0]         n_q, n_d;
  logic [CW-1:0]         word_idx_q, word_idx_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [DATA_WIDTH-9:0] word_q, word_d;
  logic                  byte_ready_q, byte_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  write_enable_q, write_enable_d;
  logic [AW-1:0]         write_addr_q, write_addr_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
`ifdef CHECKSUM_EN
  logic [7:0]            chk_q, chk_d;
`endif
  logic                  accept;
  logic [15:0]           n_full;

  assign accept = bus.byteValid && byte_ready_q;
  assign n_full = {cnt_hi_q, bus.byteData};

  always_comb begin
    state_d        = state_q;
    cnt_hi_d       = cnt_hi_q;
    base_d         = base_q;
    n_d            = n_q;
    word_idx_d     = word_idx_q;
    byte_idx_d     = byte_idx_q;
    word_d         = word_q;
    done_d         = done_q;
    error_d        = error_q;
    write_enable_d = 1'b0;
    write_addr_d   = write_addr_q;
    write_data_d   = write_data_q;
`ifdef CHECKSUM_EN
    chk_d          = chk_q;
`endif
    case (state_q)
      S_IDLE: if (accept) begin
        cnt_hi_d = bus.byteData;
        base_d   = baseAddr;
        done_d   = 1'b0;
        error_d  = 1'b0;
        state_d  = S_CNT_LO;
      end
      S_CNT_LO: if (accept) begin
        if (n_full == 16'd0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if ({1'b0, n_full} > 17'(RAM_DEPTH)) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          n_d        = n_full[CW-1:0];
          word_idx_d = '0;
          byte_idx_d = '0;
`ifdef CHECKSUM_EN
          chk_d      = 8'd0;
`endif
          state_d    = S_DATA;
        end
      end
      S_DATA: if (accept) begin
`ifdef CHECKSUM_EN
        chk_d = chk_q ^ bus.byteData;
`endif
        if (byte_idx_q == 2'd3) begin
          // Top lane goes straight to the output register; no need to store it.
          write_enable_d = 1'b1;
          write_addr_d   = base_q + word_idx_q[AW-1:0];
          write_data_d   = {bus.byteData, word_q};
          byte_idx_d     = 2'd0;
          state_d        = S_WRITE;
        end else begin
          word_d[{byte_idx_q, 3'b000} +: 8] = bus.byteData;
          byte_idx_d = byte_idx_q + 2'd1;
        end
      end
      S_WRITE: begin
        word_idx_d = word_idx_q + 1'b1;
        if (word_idx_q == n_q - 1'b1) begin
`ifdef CHECKSUM_EN
          state_d = S_CHECK;
`else
          done_d  = 1'b1;
          state_d = S_IDLE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef CHECKSUM_EN
      S_CHECK: if (accept) begin
        if (bus.byteData == chk_q) done_d = 1'b1;
        else error_d = 1'b1;
        state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    byte_ready_d = (state_d != S_WRITE);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q        <= S_IDLE;
      cnt_hi_q       <= '0;
      base_q         <= '0;
      n_q            <= '0;
      word_idx_q     <= '0;
      byte_idx_q     <= '0;
      word_q         <= '0;
      byte_ready_q   <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      write_enable_q <= 1'b0;
      write_addr_q   <= '0;
      write_data_q   <= '0;
`ifdef CHECKSUM_EN
      chk_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_hi_q       <= cnt_hi_d;
      base_q         <= base_d;
      n_q            <= n_d;
      word_idx_q     <= word_idx_d;
      byte_idx_q     <= byte_idx_d;
      word_q         <= word_d;
      byte_ready_q   <= byte_ready_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      error_q        <= error_d;
      write_enable_q <= write_enable_d;
      write_addr_q   <= write_addr_d;
      write_data_q   <= write_data_d;
`ifdef CHECKSUM_EN
      chk_q          <= chk_d;
`endif
    end
  end

  assign bus.byteReady   = byte_ready_q;
  assign bus.writeEnable = write_enable_q;
  assign bus.writeAddr   = write_addr_q;
  assign bus.writeData   = write_data_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;
endmodule
